// File: rtl/mem_stage_if.sv
// Memory bus between mem_stage (master) and the data memory / cache (slave).
// Request fields are held stable by the master for as long as mem_req is high.
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through, runs one load/store at a time on the bus.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses fault instead of being force-aligned.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [5:0]  NO_REG      = 6'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [63:0] ex_aluresult,
  input  logic [5:0]  ex_rd,
  input  logic        ex_mem_active,
  input  logic        ex_load,
  input  logic [63:0] ex_store_data,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  output logic        mem_stall,
  mem_stage_if.master bus,
  output logic        wb_valid,
  output logic [5:0]  wb_rd,
  output logic [63:0] wb_rdval,
  output logic        mem_fault,
  output logic [5:0]  fwd_rd,
  output logic [63:0] fwd_rdval
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;
  logic [7:0]  mem_wstrb_q;

  logic [2:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        load_q;
  logic [5:0]  rd_q;

  logic        wb_valid_q;
  logic [5:0]  wb_rd_q;
  logic [63:0] wb_rdval_q;
  logic        mem_fault_q;
  logic [5:0]  fwd_rd_q;
  logic [63:0] fwd_rdval_q;

  // Issue-side decode of the op presented by execute
  logic [2:0]  align_mask;
  logic [7:0]  size_strb;
  logic [2:0]  off_al;
  logic [63:0] iss_addr;
  logic [7:0]  iss_strb;
  logic [63:0] iss_wdata;
  logic [5:0]  iss_rd;

  always_comb begin
    align_mask = 3'b111;
    size_strb  = 8'h01;
    unique case (ex_size)
      2'd0: begin align_mask = 3'b111; size_strb = 8'h01; end
      2'd1: begin align_mask = 3'b110; size_strb = 8'h03; end
      2'd2: begin align_mask = 3'b100; size_strb = 8'h0F; end
      2'd3: begin align_mask = 3'b000; size_strb = 8'hFF; end
      default: ;
    endcase
    off_al    = ex_aluresult[2:0] & align_mask;
    iss_addr  = {ex_aluresult[63:3], 3'b000};
    iss_strb  = size_strb << off_al;
    iss_wdata = ex_store_data << {off_al, 3'b000};
    iss_rd    = (ex_rd == 6'd0) ? NO_REG : ex_rd;
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |(ex_aluresult[2:0] & ~align_mask);
`endif

  // Load-side lane select and extension, using the offset latched at issue
  logic [63:0] ld_shift;
  logic [63:0] ld_val;

  always_comb begin
    ld_shift = bus.mem_rdata >> {off_q, 3'b000};
    ld_val   = ld_shift;
    unique case (size_q)
      2'd0: ld_val = uns_q ? {56'd0, ld_shift[7:0]}
                           : {{56{ld_shift[7]}}, ld_shift[7:0]};
      2'd1: ld_val = uns_q ? {48'd0, ld_shift[15:0]}
                           : {{48{ld_shift[15]}}, ld_shift[15:0]};
      2'd2: ld_val = uns_q ? {32'd0, ld_shift[31:0]}
                           : {{32{ld_shift[31]}}, ld_shift[31:0]};
      2'd3: ld_val = ld_shift;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      load_q      <= 1'b0;
      rd_q        <= NO_REG;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= NO_REG;
      wb_rdval_q  <= '0;
      mem_fault_q <= 1'b0;
      fwd_rd_q    <= NO_REG;
      fwd_rdval_q <= '0;
    end else begin
      // Writeback is a one-cycle pulse; idle value of wb_rd is NO_REG
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= NO_REG;
      wb_rdval_q  <= '0;
      mem_fault_q <= 1'b0;

      if (wb_valid_q) begin
        fwd_rd_q    <= wb_rd_q;
        fwd_rdval_q <= wb_rdval_q;
      end else begin
        fwd_rd_q    <= NO_REG;
      end

      unique case (state_q)
        IDLE: begin
          if (ex_valid) begin
            if (!ex_mem_active) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= iss_rd;
              wb_rdval_q <= ex_aluresult;
            end
`ifdef MISALIGN_TRAP_EN
            else if (misaligned) begin
              wb_valid_q  <= 1'b1;
              mem_fault_q <= 1'b1;
            end
`endif
            else begin
              state_q     <= WAIT;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= ~ex_load;
              mem_addr_q  <= iss_addr;
              mem_wdata_q <= iss_wdata;
              mem_wstrb_q <= ex_load ? 8'h00 : iss_strb;
              off_q       <= off_al;
              size_q      <= ex_size;
              uns_q       <= ex_unsigned;
              load_q      <= ex_load;
              rd_q        <= iss_rd;
            end
          end
        end

        WAIT: begin
          if (bus.mem_ack) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            wb_valid_q <= 1'b1;
            if (load_q) begin
              wb_rd_q    <= rd_q;
              wb_rdval_q <= ld_val;
            end
          end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            wb_valid_q  <= 1'b1;
            mem_fault_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_stall     = (state_q == WAIT);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_rdval      = wb_rdval_q;
  assign mem_fault     = mem_fault_q;
  assign fwd_rd        = fwd_rd_q;
  assign fwd_rdval     = fwd_rdval_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against an arithmetic reference model.
// Honours MISALIGN_TRAP_EN when the design is built with it.
module tb_mem_stage;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam logic [5:0]  NO_REG      = 6'h3F;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [63:0] ex_aluresult;
  logic [5:0]  ex_rd;
  logic        ex_mem_active;
  logic        ex_load;
  logic [63:0] ex_store_data;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic        mem_stall;
  logic        wb_valid;
  logic [5:0]  wb_rd;
  logic [63:0] wb_rdval;
  logic        mem_fault;
  logic [5:0]  fwd_rd;
  logic [63:0] fwd_rdval;

  mem_stage_if bus ();

  mem_stage #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .NO_REG      (NO_REG)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_aluresult  (ex_aluresult),
    .ex_rd         (ex_rd),
    .ex_mem_active (ex_mem_active),
    .ex_load       (ex_load),
    .ex_store_data (ex_store_data),
    .ex_size       (ex_size),
    .ex_unsigned   (ex_unsigned),
    .mem_stall     (mem_stall),
    .bus           (bus),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_rdval      (wb_rdval),
    .mem_fault     (mem_fault),
    .fwd_rd        (fwd_rd),
    .fwd_rdval     (fwd_rdval)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bytes starting at the (size-aligned) offset, zero/sign extended
  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [2:0] off,
                                           input int nb, input bit uns);
    logic [63:0] v, m;
    v = rdata >> (8 * off);
    if (nb < 8) begin
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if (!uns && v[8*nb-1]) v = v | ~m;
    end
    return v;
  endfunction

  function automatic logic [5:0] ref_rd(input logic [5:0] rd);
    return (rd == 6'd0) ? NO_REG : rd;
  endfunction

  task automatic do_alu(input logic [5:0] rd, input logic [63:0] val);
    ex_valid = 1'b1; ex_mem_active = 1'b0; ex_rd = rd; ex_aluresult = val;
    ex_load = $urandom_range(0, 1); ex_store_data = {$urandom, $urandom};
    tick();
    ex_valid = 1'b0;
    check("alu_wb_valid", wb_valid, 1'b1);
    check("alu_wb_rd", wb_rd, ref_rd(rd));
    check("alu_wb_rdval", wb_rdval, val);
    check("alu_stall", mem_stall, 1'b0);
    check("alu_req", bus.mem_req, 1'b0);
    tick();
    check("alu_wb_idle", wb_valid, 1'b0);
    check("alu_wb_rd_idle", wb_rd, NO_REG);
    check("alu_fwd_rd", fwd_rd, ref_rd(rd));
    check("alu_fwd_rdval", fwd_rdval, val);
  endtask

  // ack_dly = 0 means the bus never answers
  task automatic do_mem(input bit load, input logic [63:0] addr, input logic [1:0] size,
                        input bit uns, input logic [63:0] sdata, input logic [5:0] rd,
                        input logic [63:0] rdata, input int ack_dly);
    int          nb;
    int          budget;
    logic [2:0]  eoff;
    logic [5:0]  exp_rd;
    logic [63:0] exp_addr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    nb        = 1 << size;
    eoff      = addr[2:0] & ~3'(nb - 1);
    exp_addr  = addr & ~64'd7;
    exp_strb  = 8'((16'd1 << nb) - 16'd1) << eoff;
    exp_wdata = sdata << (8 * eoff);
    ex_valid = 1'b1; ex_mem_active = 1'b1; ex_load = load; ex_aluresult = addr;
    ex_size = size; ex_unsigned = uns; ex_store_data = sdata; ex_rd = rd;
    tick();
`ifdef MISALIGN_TRAP_EN
    if (addr[2:0] != eoff) begin
      ex_valid = 1'b0;
      check("trap_wb_valid", wb_valid, 1'b1);
      check("trap_fault", mem_fault, 1'b1);
      check("trap_wb_rd", wb_rd, NO_REG);
      check("trap_req", bus.mem_req, 1'b0);
      check("trap_stall", mem_stall, 1'b0);
      tick();
      check("trap_wb_idle", wb_valid, 1'b0);
      return;
    end
`endif
    budget = (ack_dly == 0) ? int'(TIMEOUT_CYC) : ack_dly;
    for (int n = 1; n <= budget; n++) begin
      check("wait_stall", mem_stall, 1'b1);
      check("wait_req", bus.mem_req, 1'b1);
      check("wait_wb_valid", wb_valid, 1'b0);
      check("bus_addr", bus.mem_addr, exp_addr);
      check("bus_we", bus.mem_we, !load);
      if (!load) begin
        check("bus_wstrb", bus.mem_wstrb, exp_strb);
        check("bus_wdata", bus.mem_wdata, exp_wdata);
      end
      bus.mem_rdata = (n == ack_dly) ? rdata : {$urandom, $urandom};
      bus.mem_ack   = (n == ack_dly);
      tick();
      bus.mem_ack = 1'b0;
    end
    ex_valid = 1'b0;
    exp_rd = (ack_dly == 0 || !load) ? NO_REG : ref_rd(rd);
    check("done_req", bus.mem_req, 1'b0);
    check("done_stall", mem_stall, 1'b0);
    check("done_wb_valid", wb_valid, 1'b1);
    check("done_fault", mem_fault, ack_dly == 0);
    check("done_wb_rd", wb_rd, exp_rd);
    if (load && ack_dly != 0)
      check("load_rdval", wb_rdval, ref_load(rdata, eoff, nb, uns));
    tick();
    check("post_wb_idle", wb_valid, 1'b0);
    check("post_wb_rd", wb_rd, NO_REG);
    check("post_fault", mem_fault, 1'b0);
    check("post_fwd_rd", fwd_rd, exp_rd);
    if (load && ack_dly != 0)
      check("post_fwd_rdval", fwd_rdval, ref_load(rdata, eoff, nb, uns));
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_req"},    bus.mem_req, 1'b0);
    check({pfx, "_we"},     bus.mem_we, 1'b0);
    check({pfx, "_wstrb"},  bus.mem_wstrb, 8'h00);
    check({pfx, "_addr"},   bus.mem_addr, 64'd0);
    check({pfx, "_wdata"},  bus.mem_wdata, 64'd0);
    check({pfx, "_stall"},  mem_stall, 1'b0);
    check({pfx, "_wbv"},    wb_valid, 1'b0);
    check({pfx, "_fault"},  mem_fault, 1'b0);
    check({pfx, "_wbrd"},   wb_rd, NO_REG);
    check({pfx, "_wbval"},  wb_rdval, 64'd0);
    check({pfx, "_fwdrd"},  fwd_rd, NO_REG);
    check({pfx, "_fwdval"}, fwd_rdval, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_aluresult = '0; ex_rd = '0; ex_mem_active = 1'b0;
    ex_load = 1'b0; ex_store_data = '0; ex_size = '0; ex_unsigned = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    do_alu(6'd5, 64'h1234);
    do_alu(6'd0, 64'hDEAD_BEEF);
    do_mem(1'b1, 64'h1003, 2'd0, 1'b0, 64'd0, 6'd7, 64'h00000000_80000000, 3);
    do_mem(1'b0, 64'h2006, 2'd1, 1'b0, 64'hBEEF, 6'd9, 64'd0, 1);
    do_mem(1'b1, 64'h3002, 2'd2, 1'b1, 64'd0, 6'd10, 64'h11223344_55667788, 2);
    do_mem(1'b1, 64'h4000, 2'd3, 1'b0, 64'd0, 6'd11, 64'd0, 0);
    do_mem(1'b1, 64'h5008, 2'd3, 1'b0, 64'd0, 6'd0, 64'hCAFE_F00D_1234_5678, 1);

    // Reset while waiting, with a stale ack right after
    ex_valid = 1'b1; ex_mem_active = 1'b1; ex_load = 1'b1; ex_aluresult = 64'h6000;
    ex_size = 2'd3; ex_rd = 6'd12;
    tick();
    check("rw_stall", mem_stall, 1'b1);
    tick();
    reset = 1'b1; ex_valid = 1'b0;
    tick();
    reset = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 64'h1111_2222_3333_4444;
    check_reset_vals("rw");
    tick();
    bus.mem_ack = 1'b0;
    check("rw_late_wbv", wb_valid, 1'b0);
    check("rw_late_req", bus.mem_req, 1'b0);
    check("rw_late_stall", mem_stall, 1'b0);
    tick();
    check("rw_late2_wbv", wb_valid, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int          kind;
      int          dly;
      logic [63:0] a;
      kind = $urandom_range(0, 2);
      dly  = ($urandom_range(0, 14) == 0) ? 0 : $urandom_range(1, 5);
      a    = {$urandom, $urandom};
      if (kind == 0)
        do_alu(6'($urandom_range(0, 63)), a);
      else
        do_mem(kind == 1, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, 6'($urandom_range(0, 63)), {$urandom, $urandom}, dly);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
